// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [31:0] MDU_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MDU_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operandA;
    logic [XLEN-1:0] operandB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operandA, operandB,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operandA, operandB,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    input  logic [XLEN-1:0]   opnd,     // multiplicand or divisor magnitude
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;

    // Select between add-and-shift-right and shift-left-and-try-subtract
    always_comb begin
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        trial = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        diff  = {1'b0, trial} - {2'b00, opnd};
        if (!is_div) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else if (!diff[XLEN+1]) begin
            acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: FSM, counter, sign handling and result register.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = mdu_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam logic [XLEN-1:0]   ONE      = 1;
    localparam logic [2*XLEN-1:0] ONE2     = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN - 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;

    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              in_div, div_zero, div_ovf;

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (step_acc)
    );

    // Operand decode for a request arriving on the bus this cycle
    always_comb begin
        in_div   = bus.funct3[2];
        a_signed = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_MULHSU) ||
                   (bus.funct3 == MDU_DIV)  || (bus.funct3 == MDU_REM);
        b_signed = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_DIV) ||
                   (bus.funct3 == MDU_REM);
        a_neg    = a_signed && bus.operandA[XLEN-1];
        b_neg    = b_signed && bus.operandB[XLEN-1];
        a_mag    = a_neg ? (~bus.operandA + ONE) : bus.operandA;
        b_mag    = b_neg ? (~bus.operandB + ONE) : bus.operandB;
        div_zero = in_div && (bus.operandB == '0);
        div_ovf  = in_div && !bus.funct3[0] &&
                   (bus.operandA == MDU_INT_MIN) && (bus.operandB == MDU_ALL_ONES);
    end

    // Next-state, datapath and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;

        prod    = neg_q ? (~step_acc + ONE2) : step_acc;
        div_sel = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];

        if (state_q == CALC) begin
            acc_d = step_acc;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
                state_d = DONE;
                if (!op_q[2]) begin
                    result_d = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end else begin
                    result_d = neg_q ? (~div_sel + ONE) : div_sel;
                end
            end
        end else begin
            state_d = IDLE;
            if (bus.start) begin
                op_d = bus.funct3;
                if (div_zero) begin
                    state_d  = DONE;
                    result_d = bus.funct3[1] ? bus.operandA : MDU_ALL_ONES;
                end else if (div_ovf) begin
                    state_d  = DONE;
                    result_d = bus.funct3[1] ? '0 : MDU_INT_MIN;
                end else begin
                    state_d = CALC;
                    cnt_d   = CNT_INIT;
                    if (in_div) begin
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                        opnd_d = b_mag;
                        // remainder follows the dividend, quotient follows the sign product
                        neg_d  = bus.funct3[1] ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                        opnd_d = a_mag;
                        neg_d  = a_neg ^ b_neg;
                    end
                end
            end
        end
    end

    // State register with synchronous reset that also aborts an in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences, random vs. model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural RV32M semantics using plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called #1 after a posedge; drives a request sampled at the next edge (cycle 0)
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.operandA = a;
        bus.operandB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Observes cycles 1.. until done; optionally injects a competing start at cycle 'inject'
    task automatic wait_done(input int inject, output int done_cyc, output int busy_cnt,
                             output bit overlap, output bit hold_bad);
        done_cyc = -1;
        busy_cnt = 0;
        overlap  = 1'b0;
        hold_bad = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.result !== held) hold_bad = 1'b1;
            if (cyc == inject) begin
                bus.start    = 1'b1;
                bus.funct3   = 3'd5;
                bus.operandA = 32'h0000_1234;
                bus.operandB = 32'h0;
            end
            if (cyc == inject + 1) bus.start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int inject);
        int dc, bc;
        bit ov, hb, fast;
        fast = is_fast(f3, a, b);
        issue(f3, a, b);
        wait_done(inject, dc, bc, ov, hb);
        check({name, " result"}, bus.result, exp);
        check({name, " done_cycle"}, dc, fast ? 32'd1 : 32'd33);
        check({name, " busy_cycles"}, bc, fast ? 32'd0 : 32'd32);
        check({name, " busy_with_done"}, {31'b0, ov}, 32'd0);
        check({name, " result_hold"}, {31'b0, hb}, 32'd0);
        held = exp;
        $display("op %s f3=%0d a=%h b=%h result=%h done_cycle=%0d", name, f3, a, b, bus.result, dc);
    endtask

    initial begin
        int  gap, sel;
        bit  saw_done;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = 3'd0;
        bus.operandA = 32'h0;
        bus.operandB = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        reset = 1'b0;
        held  = 32'h0;

        // Directed table; each op issues from the previous DONE cycle (back-to-back)
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, -1);
        end

        // Competing start at cycle 10 of a MUL must be ignored
        @(posedge clk); #1;
        run_op("mul_ignore_start", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);

        // Reset in cycle 15 of a DIV aborts it without a done pulse
        @(posedge clk); #1;
        issue(3'd4, 32'hFFFF_FF00, 32'h0000_0003);
        repeat (14) begin @(posedge clk); #1; end
        check("div_abort busy_before_reset", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("div_abort busy", {31'b0, bus.busy}, 32'd0);
        check("div_abort done", {31'b0, bus.done}, 32'd0);
        check("div_abort result", bus.result, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("div_abort no_activity", {31'b0, saw_done}, 32'd0);
        held = 32'h0;
        run_op("div_after_reset", 3'd4, 32'hFFFF_FF00, 32'h0000_0003,
               ref_model(3'd4, 32'hFFFF_FF00, 32'h0000_0003), -1);

        // Randomized ops against the reference model, with occasional idle gaps
        for (int n = 0; n < 250; n++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(1, 9)); end
            else if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            run_op($sformatf("rnd%0d", n), f3, a, b, ref_model(f3, a, b), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit. It sits directly downstream of the register file and consumes readData1 and readData2 as operands. Its result goes to the writeback mux in place of the ALU result.
It is multi-cycle: the core control logic stalls PC/regWrite while busy is high and writes result back when done pulses.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operandA  input  XLEN  rs1 value (readData1)
operandB  input  XLEN  rs2 value (readData2)
busy  output  1  high while iterating; start ignored
done  output  1  one-cycle pulse; result valid
result  output  XLEN  final value, held until next accepted start or reset

Behaviour:
- Reset (synchronous, reset=1 at posedge): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared. This applies even mid-operation; the in-flight op is discarded with no done pulse.
- States: IDLE, CALC, DONE.
- Start acceptance: start=1 in IDLE or DONE, i.e. busy=0. Back-to-back issue from the DONE cycle is legal.
- On acceptance, latch funct3 and operands, and compute sign flags:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: operandA signed, operandB unsigned.
  - All other ops: both operands unsigned.
  - Convert signed operands to magnitudes.
- Fast path, taken at acceptance and going straight to DONE:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operandA.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Normal path: go to CALC with counter=XLEN-1, then perform one step per cycle for XLEN cycles. Leave CALC when counter=0.
  - Multiply: radix-2 shift-add over a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
- Leaving CALC: apply sign fix-up and register result, then enter DONE.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
- Timing, with cycle 0 being the acceptance edge:
  - Normal op: busy=1 in cycles 1..32, done=1 in cycle 33.
  - Fast path: done=1 in cycle 1 and busy never asserts.
- DONE lasts one cycle. It goes to IDLE, or to CALC/DONE if a new start is accepted in that cycle.
- done is never high together with busy. result changes only on the cycle done rises, or on reset.
- start while busy=1 is ignored entirely; there is no queueing and latched operands are unaffected.
- funct3 is decoded from the latched copy only, so input changes after acceptance have no effect.

Decomposition:
- Shared package mdu_pkg holds:
  - funct3 localparams (MDU_MUL..MDU_REMU);
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the XLEN default;
  - the constants 0x80000000 and 0xFFFFFFFF.
- One sub-module, mdu_iter_step: combinational single-step datapath (shift-add or shift-subtract) selected by an is_div input. The parent holds the FSM, counter, sign logic and registers.

Test Plan:
- MUL: A=7, B=0xFFFFFFFD (-3), start at cycle 0 -> busy cycles 1..32; done at cycle 33 with result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14 and REMU 100/7 -> 2, issued back-to-back from the DONE cycle.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done at cycle 1 with busy never high. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- start with different operands at cycle 10 of a MUL -> ignored; original result delivered at cycle 33.
- reset=1 at cycle 15 of a DIV -> next cycle busy=0, done=0, result=0; no done pulse follows; a fresh op then completes correctly.
